// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// Port sub exists only when SERIAL_ADD_CTRL_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) reused LSB-first.
// Define SERIAL_ADD_CTRL_SUB_EN to add subtraction via the sub input.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s1, c1, s, c2;

  always_comb begin
    s1      = opa_q[0] ^ opb_q[0];
    c1      = opa_q[0] & opb_q[0];
    s       = s1 ^ carry_q;
    c2      = s1 & carry_q;
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_ADD_CTRL_SUB_EN
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
`else
          opb_d   = bus.b;
          carry_d = 1'b0;
`endif
        end
      end
      RUN: begin
        carry_d          = c1 | c2;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = s;
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        cnt_d            = cnt_q + 1'b1;
        // Last bit: publish the result including this edge's sum bit and carry.
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = c1 | c2;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sub(input logic sv);
`ifdef SERIAL_ADD_CTRL_SUB_EN
    bus.sub = sv;
`endif
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic sv);
    logic [W:0] r;
    if (sv) begin
      r[W-1:0] = av - bv;
      r[W]     = (av >= bv);
    end else begin
      r = {1'b0, av} + {1'b0, bv};
    end
    return r;
  endfunction

  // Drives one operation and collects observations; callers do the comparisons.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input bit noise, output logic [W-1:0] rs, output logic rc,
                        output int lat, output bit busy0, output bit held, output bit one_done);
    logic [W-1:0] prev_s;
    logic         prev_c;
    prev_s = bus.sum;
    prev_c = bus.cout;
    held   = 1'b1;
    bus.a = av; bus.b = bv; set_sub(sv); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    busy0 = (bus.busy === 1'b1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.sum !== prev_s || bus.cout !== prev_c) held = 1'b0;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a = W'($urandom); bus.b = W'($urandom); set_sub(1'($urandom_range(0, 1)));
      end
      step();
      lat++;
    end
    rs = bus.sum;
    rc = bus.cout;
    if (noise) begin
      bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
    end
    step();
    bus.start = 1'b0;
    one_done = (bus.done === 1'b0) && (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; set_sub(1'b0);
    rst_n = 1'b0;
    #23;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b sum=%h cout=%b expected all 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_basic_add();
    logic [W-1:0] rs; logic rc; int lat; bit b0, held, od;
    logic [W-1:0] av [3] = '{8'h00, 8'hFF, 8'hA5};
    logic [W-1:0] bv [3] = '{8'h00, 8'h01, 8'h5A};
    logic [W:0]   exp;
    for (int i = 0; i < 3; i++) begin
      exp = model(av[i], bv[i], 1'b0);
      run_op(av[i], bv[i], 1'b0, 1'b0, rs, rc, lat, b0, held, od);
      checks++;
      if (rs !== exp[W-1:0] || rc !== exp[W]) begin
        errors++;
        $display("FAIL basic_add[%0d]: sum=%h cout=%b expected sum=%h cout=%b",
                 i, rs, rc, exp[W-1:0], exp[W]);
      end
      checks++;
      if (lat != W || !b0 || !od) begin
        errors++;
        $display("FAIL basic_timing[%0d]: latency=%0d busy0=%b single_done=%b expected %0d,1,1",
                 i, lat, b0, od, W);
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL basic_held[%0d]: previous result changed before done, expected held", i);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] exp; int lat, dones; bit timeout;
    exp = model(8'h12, 8'h34, 1'b0);
    bus.a = 8'h12; bus.b = 8'h34; set_sub(1'b0); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0; dones = 0; timeout = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.start = (lat == 3) || (bus.done === 1'b1);
      bus.a = bus.start ? 8'hFF : 8'h12;
      bus.b = bus.start ? 8'hFF : 8'h34;
      if (bus.done === 1'b1) begin
        dones++;
        timeout = 1'b0;
        checks++;
        if (bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin
          errors++;
          $display("FAIL ignore_result: sum=%h cout=%b expected sum=%h cout=%b",
                   bus.sum, bus.cout, exp[W-1:0], exp[W]);
        end
      end
      step();
      lat++;
      bus.start = 1'b0;
    end
    checks++;
    if (timeout || dones != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_count: dones=%0d busy=%b expected 1 done then idle",
               dones, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] rs; logic rc; int lat; bit b0, held, od, saw_done;
    bus.a = 8'h80; bus.b = 8'h80; set_sub(1'b0); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b done=%b sum=%h cout=%b expected all 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    step(); step();
    #3 rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: activity seen after abort=1 expected 0");
    end
    run_op(8'h80, 8'h80, 1'b0, 1'b0, rs, rc, lat, b0, held, od);
    checks++;
    if (rs !== 8'h00 || rc !== 1'b1 || lat != W) begin
      errors++;
      $display("FAIL abort_restart: sum=%h cout=%b latency=%0d expected sum=00 cout=1 latency=%0d",
               rs, rc, lat, W);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rs; logic rc; int lat; bit b0, held, od;
    logic [W:0] exp;
    int done_at [3];
    int nd;
    run_op(8'h11, 8'h22, 1'b0, 1'b0, rs, rc, lat, b0, held, od);
    exp = model(8'h3C, 8'hE0, 1'b0);
    run_op(8'h3C, 8'hE0, 1'b0, 1'b0, rs, rc, lat, b0, held, od);
    checks++;
    if (rs !== exp[W-1:0] || rc !== exp[W] || lat != W || !b0) begin
      errors++;
      $display("FAIL b2b_second: sum=%h cout=%b latency=%0d busy0=%b expected sum=%h cout=%b latency=%0d busy0=1",
               rs, rc, lat, b0, exp[W-1:0], exp[W], W);
    end
    exp = model(8'h33, 8'h44, 1'b0);
    bus.a = 8'h33; bus.b = 8'h44; set_sub(1'b0); bus.start = 1'b1;
    nd = 0;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      step();
      if (bus.done === 1'b1) begin
        done_at[nd] = c;
        nd++;
        checks++;
        if (bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin
          errors++;
          $display("FAIL stream_result: sum=%h cout=%b expected sum=%h cout=%b",
                   bus.sum, bus.cout, exp[W-1:0], exp[W]);
        end
      end
    end
    bus.start = 1'b0;
    step();
    checks++;
    if (nd != 3 || done_at[1] - done_at[0] != W + 2 || done_at[2] - done_at[1] != W + 2) begin
      errors++;
      $display("FAIL stream_period: dones=%0d intervals=%0d,%0d expected 3 dones every %0d",
               nd, done_at[1] - done_at[0], done_at[2] - done_at[1], W + 2);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, rs; logic sv, rc; int lat; bit b0, held, od;
    logic [W:0] exp;
    for (int i = 0; i < 20; i++) begin
      av = W'($urandom); bv = W'($urandom);
`ifdef SERIAL_ADD_CTRL_SUB_EN
      sv = 1'($urandom_range(0, 1));
`else
      sv = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) step();
      exp = model(av, bv, sv);
      run_op(av, bv, sv, 1'b1, rs, rc, lat, b0, held, od);
      checks++;
      if (rs !== exp[W-1:0] || rc !== exp[W] || lat != W || !b0 || !held || !od) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h sub=%b: sum=%h cout=%b lat=%0d busy0=%b held=%b single=%b expected sum=%h cout=%b lat=%0d",
                 i, av, bv, sv, rs, rc, lat, b0, held, od, exp[W-1:0], exp[W], W);
      end
    end
  endtask

`ifdef SERIAL_ADD_CTRL_SUB_EN
  task automatic test_sub();
    logic [W-1:0] rs; logic rc; int lat; bit b0, held, od;
    run_op(8'h05, 8'h07, 1'b1, 1'b0, rs, rc, lat, b0, held, od);
    checks++;
    if (rs !== 8'hFE || rc !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: sum=%h cout=%b expected sum=fe cout=0", rs, rc);
    end
    run_op(8'h07, 8'h05, 1'b1, 1'b0, rs, rc, lat, b0, held, od);
    checks++;
    if (rs !== 8'h02 || rc !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: sum=%h cout=%b expected sum=02 cout=1", rs, rc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_CTRL_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
